// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: step modes and FSM states.
package univ_shift_pkg;

  localparam logic [2:0] MODE_SLL   = 3'b000;
  localparam logic [2:0] MODE_SRL   = 3'b001;
  localparam logic [2:0] MODE_SRA   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_SER_L = 3'b101;
  localparam logic [2:0] MODE_SER_R = 3'b110;
  localparam logic [2:0] MODE_HOLD  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_step.sv
// Combinational single-bit step of the shift register for one of eight modes.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SLL:   nxt = {cur[WIDTH-2:0], 1'b0};
      MODE_SRL:   nxt = {1'b0, cur[WIDTH-1:1]};
      MODE_SRA:   nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_SER_L: nxt = {cur[WIDTH-2:0], ser_in_r};
      MODE_SER_R: nxt = {ser_in_l, cur[WIDTH-1:1]};
      default:    nxt = cur;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register that applies a captured mode amt times, one bit per
// clock, under a start/busy/done handshake with early abort.
module univ_shift_reg_seq
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_an,
  input  logic [WIDTH-1:0] ip,
  input  logic             load,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             start,
  input  logic             abort,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] op,
  output logic             busy,
  output logic             done,
  output logic             ser_out_l,
  output logic             ser_out_r
);

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] step_nxt;
  logic             done_q, done_d;

  univ_shift_step #(.WIDTH(WIDTH)) u_step (
    .cur      (op_q),
    .mode     (mode_q),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .nxt      (step_nxt)
  );

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      op_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    op_d    = op_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // load takes priority over start in the same cycle
        if (load) begin
          op_d = ip;
        end else if (start) begin
          if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode;
            cnt_d   = amt;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // abort leaves the partial result in place and suppresses done
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          op_d  = step_nxt;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign op        = op_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign ser_out_l = op_q[WIDTH-1];
  assign ser_out_r = op_q[0];

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Self-checking bench: closed-form reference model compared every cycle, plus
// hand-computed literal expectations along directed scenarios.
module tb_univ_shift_reg_seq;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_an;
  logic [W-1:0]  ip;
  logic          load;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic          start;
  logic          abort;
  logic          ser_in_l;
  logic          ser_in_r;
  logic [W-1:0]  op;
  logic          busy;
  logic          done;
  logic          ser_out_l;
  logic          ser_out_r;

  int n_cmp  = 0;
  int n_fail = 0;

  univ_shift_reg_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk       (clk),
    .rst_an    (rst_an),
    .ip        (ip),
    .load      (load),
    .mode      (mode),
    .amt       (amt),
    .start     (start),
    .abort     (abort),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r)
  );

  always #5 clk = ~clk;

  // Expected word after j steps of mode from base; serial modes advance cur.
  function automatic logic [W-1:0] expect_after(input logic [W-1:0] base,
      input logic [W-1:0] cur, input logic [2:0] md, input int j,
      input logic sl, input logic sr);
    logic [2*W-1:0] dbl;
    int r;
    r   = j % W;
    dbl = {base, base};
    case (md)
      3'd0: return (j >= W) ? '0 : W'(base << j);
      3'd1: return (j >= W) ? '0 : W'(base >> j);
      3'd2: return W'($signed(base) >>> j);
      3'd3: begin dbl = dbl << r; return dbl[2*W-1:W]; end
      3'd4: begin dbl = dbl >> r; return dbl[W-1:0]; end
      3'd5: return {cur[W-2:0], sr};
      3'd6: return {sl, cur[W-1:1]};
      default: return base;
    endcase
  endfunction

  logic [W-1:0] m_op, m_base;
  logic [2:0]   m_mode;
  logic         m_run, m_done;
  int           m_j, m_k;

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      m_op <= '0; m_base <= '0; m_mode <= 3'd7;
      m_run <= 1'b0; m_done <= 1'b0; m_j <= 0; m_k <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_run) begin
        if (load) m_op <= ip;
        else if (start) begin
          if (amt == 0) m_done <= 1'b1;
          else begin
            m_run <= 1'b1; m_base <= m_op; m_mode <= mode;
            m_k <= int'(amt); m_j <= 0;
          end
        end
      end else if (abort) begin
        m_run <= 1'b0;
      end else begin
        m_op <= expect_after(m_base, m_op, m_mode, m_j + 1, ser_in_l, ser_in_r);
        m_j  <= m_j + 1;
        if (m_j + 1 == m_k) begin
          m_run <= 1'b0; m_done <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_op", op, m_op);
    chk("model_busy", W'(busy), W'(m_run));
    chk("model_done", W'(done), W'(m_done));
    chk("model_sol", W'(ser_out_l), W'(m_op[W-1]));
    chk("model_sor", W'(ser_out_r), W'(m_op[0]));
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    ip = v; load = 1'b1; nxt(); load = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] md, input logic [AW-1:0] a);
    mode = md; amt = a; start = 1'b1; nxt(); start = 1'b0;
  endtask

  initial begin
    rst_an = 1'b0; ip = '0; load = 0; mode = 0; amt = 0; start = 0;
    abort = 0; ser_in_l = 0; ser_in_r = 0;
    nxt(); nxt();
    chk("reset_op", op, 8'h00);
    chk("reset_busy", W'(busy), 8'h00);
    chk("reset_done", W'(done), 8'h00);
    rst_an = 1'b1;
    nxt();

    do_load(8'h08);
    chk("load_op", op, 8'h08);
    chk("load_busy", W'(busy), 8'h00);
    chk("load_done", W'(done), 8'h00);

    // ROL by 3 from 81
    do_load(8'h81);
    do_start(3'd3, 4'd3);
    chk("rol_e0_busy", W'(busy), 8'h01);
    chk("rol_e0_op", op, 8'h81);
    nxt(); chk("rol_e1", op, 8'h03);
    nxt(); chk("rol_e2", op, 8'h06); chk("rol_e2_busy", W'(busy), 8'h01);
    chk("rol_e2_done", W'(done), 8'h00);
    nxt(); chk("rol_e3", op, 8'h0C);
    chk("rol_e3_busy", W'(busy), 8'h00); chk("rol_e3_done", W'(done), 8'h01);
    nxt(); chk("rol_done_pulse", W'(done), 8'h00);

    // SRA 2, SRL 9 (over-width) from 90
    do_load(8'h90);
    do_start(3'd2, 4'd2);
    repeat (2) nxt();
    chk("sra2", op, 8'hE4);
    do_load(8'h90);
    do_start(3'd1, 4'd9);
    repeat (8) nxt();
    chk("srl9_busy", W'(busy), 8'h01);
    nxt();
    chk("srl9", op, 8'h00); chk("srl9_done", W'(done), 8'h01);

    // Over-width rotate and SRA
    do_load(8'h81);
    do_start(3'd3, 4'd9);
    repeat (9) nxt();
    chk("rol9", op, 8'h03);
    do_load(8'h90);
    do_start(3'd2, 4'd12);
    repeat (12) nxt();
    chk("sra12", op, 8'hFF);
    do_load(8'h81);
    do_start(3'd4, 4'd10);
    repeat (10) nxt();
    chk("ror10", op, 8'h60);

    // Serial left: 1,0,1,1 into LSB
    do_load(8'h00);
    do_start(3'd5, 4'd4);
    ser_in_r = 1'b1; nxt(); chk("serl_1", op, 8'h01);
    ser_in_r = 1'b0; nxt(); chk("serl_2", op, 8'h02);
    ser_in_r = 1'b1; nxt(); chk("serl_3", op, 8'h05);
    ser_in_r = 1'b1; nxt(); chk("serl_4", op, 8'h0B);
    ser_in_r = 1'b0;

    // Serial right with ser_out ports
    do_load(8'hC3);
    chk("sol_c3", W'(ser_out_l), 8'h01);
    chk("sor_c3", W'(ser_out_r), 8'h01);
    do_start(3'd6, 4'd2);
    ser_in_l = 1'b0; nxt();
    ser_in_l = 1'b1; nxt();
    chk("serr_2", op, 8'hB0);
    ser_in_l = 1'b0;

    // Abort after 2 steps, load during RUN ignored
    do_load(8'h01);
    do_start(3'd0, 4'd5);
    nxt(); chk("ab_e1", op, 8'h02);
    ip = 8'hFF; load = 1'b1;
    nxt(); chk("ab_e2_load_ignored", op, 8'h04);
    load = 1'b0; abort = 1'b1;
    nxt(); abort = 1'b0;
    chk("ab_op", op, 8'h04); chk("ab_busy", W'(busy), 8'h00);
    chk("ab_done", W'(done), 8'h00);
    do_start(3'd4, 4'd1);
    chk("post_ab_busy", W'(busy), 8'h01);
    nxt(); chk("post_ab_op", op, 8'h02); chk("post_ab_done", W'(done), 8'h01);
    // back-to-back start with amt=0 while done is high
    do_start(3'd0, 4'd0);
    chk("b2b_done", W'(done), 8'h01); chk("b2b_op", op, 8'h02);

    // abort while idle is ignored
    abort = 1'b1; nxt(); abort = 1'b0;
    chk("idle_abort_op", op, 8'h02);

    // Asynchronous reset mid-RUN
    do_start(3'd3, 4'd5);
    nxt();
    #2 rst_an = 1'b0;
    #1;
    chk("arst_op", op, 8'h00); chk("arst_busy", W'(busy), 8'h00);
    nxt(); rst_an = 1'b1;
    do_load(8'h5A);
    do_start(3'd0, 4'd0);
    chk("amt0_done", W'(done), 8'h01); chk("amt0_op", op, 8'h5A);
    nxt(); chk("amt0_pulse", W'(done), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
